// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller wrapped around an external
// 8-bit combinational ALU, with an internal 8x8 register file.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   instr_valid/ready    instruction handshake (ready only in IDLE)
//   instr[15:0]          {op[2:0], use_imm, rd[2:0], rs1[2:0], imm6|rs2}
//   alu_a/alu_b/alu_op   registered ALU operands and opcode
//   alu_result[15:0]     combinational ALU result
//   done, done_result    one-cycle completion pulse and captured result
//   zero_flag            last captured result was zero
//   dz_err               sticky divide/modulo by zero
//   dbg_addr, dbg_data   combinational register-file debug read
module alu_sequencer #(
    parameter bit         MUL_HI_WB = 1'b1,
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        done,
    output logic [15:0] done_result,
    output logic        zero_flag,
    output logic        dz_err,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_regs [8];
    logic [2:0]  r_rd;
    logic [2:0]  r_op;
    logic [15:0] r_res;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_done;
    logic [15:0] r_done_result;
    logic        r_zero;
    logic        r_dz;

    logic [2:0]  w_opcode;
    logic        w_use_imm;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs1;
    logic [2:0]  w_rs2;
    logic [7:0]  w_b;
    logic        w_is_div;
    logic        w_mul_hi;
    logic [2:0]  w_rd_hi;

    assign w_opcode  = instr[15:13];
    assign w_use_imm = instr[12];
    assign w_rd      = instr[11:9];
    assign w_rs1     = instr[8:6];
    assign w_rs2     = instr[5:3];
    assign w_b       = w_use_imm ? {2'b00, instr[5:0]} : r_regs[w_rs2];
    assign w_is_div  = (w_opcode == 3'b011) || (w_opcode == 3'b100);

    // Multiply takes an extra writeback cycle for the high byte.
    assign w_mul_hi  = MUL_HI_WB && (r_op == 3'b010);

    // 3-bit add wraps rd=7 onto r0.
    assign w_rd_hi   = r_rd + 3'd1;

    assign instr_ready = (r_state == IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign done        = r_done;
    assign done_result = r_done_result;
    assign zero_flag   = r_zero;
    assign dz_err      = r_dz;
    assign dbg_data    = r_regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rd          <= 3'd0;
            r_op          <= 3'd0;
            r_res         <= 16'h0000;
            r_alu_a       <= 8'h00;
            r_alu_b       <= 8'h00;
            r_alu_op      <= 3'd0;
            r_done        <= 1'b0;
            r_done_result <= 16'h0000;
            r_zero        <= 1'b0;
            r_dz          <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= REG_RESET;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_alu_a  <= r_regs[w_rs1];
                        r_alu_b  <= w_b;
                        r_alu_op <= w_opcode;
                        r_rd     <= w_rd;
                        r_op     <= w_opcode;
                        if (w_is_div && (w_b == 8'h00)) begin
                            r_dz <= 1'b1;
                        end
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res  <= alu_result;
                    r_zero <= (alu_result == 16'h0000);
                    // done is registered, so raise it here to land in
                    // the final writeback cycle.
                    if (!w_mul_hi) begin
                        r_done        <= 1'b1;
                        r_done_result <= alu_result;
                    end
                    r_state <= WB_LO;
                end
                WB_LO: begin
                    r_regs[r_rd] <= r_res[7:0];
                    if (w_mul_hi) begin
                        r_done        <= 1'b1;
                        r_done_result <= r_res;
                        r_state       <= WB_HI;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WB_HI: begin
                    r_regs[w_rd_hi] <= r_res[15:8];
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a
// behavioural ALU, a register-file model and a result scoreboard.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        done;
    logic [15:0] done_result;
    logic        zero_flag;
    logic        dz_err;
    logic [2:0]  dbg_addr = 3'd0;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_reg [8];
    logic        m_dz;
    logic [15:0] sb [$];

    always #10 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0: return {8'h00, a} + {8'h00, b};
            3'd1: return {8'h00, 8'(a - b)};
            3'd2: return {8'h00, a} * {8'h00, b};
            3'd3: return (b == 8'h00) ? 16'h0000 : {8'h00, 8'(a / b)};
            3'd4: return (b == 8'h00) ? 16'h0000 : {8'h00, 8'(a % b)};
            3'd5: return {15'h0, a == b};
            3'd6: return {15'h0, a < b};
            default: return {15'h0, a > b};
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .done        (done),
        .done_result (done_result),
        .zero_flag   (zero_flag),
        .dz_err      (dz_err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    function automatic logic [15:0] mk(input logic [2:0] op,
                                       input logic ui,
                                       input logic [2:0] rd,
                                       input logic [2:0] rs1,
                                       input logic [5:0] lo);
        return {op, ui, rd, rs1, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== m_reg[i]) begin
                errors++;
                $display("FAIL %s reg r%0d: got %h expected %h",
                         tag, i, dbg_data, m_reg[i]);
            end
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] r,
                             input logic [7:0] v);
        dbg_addr = r;
        #1;
        checks++;
        if (dbg_data !== v) begin
            errors++;
            $display("FAIL %s: r%0d got %h expected %h", tag, r, dbg_data, v);
        end
    endtask

    task automatic issue(input logic [15:0] ins);
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rdh;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          n;
        int          exp_lat;
        op  = ins[15:13];
        rd  = ins[11:9];
        rdh = rd + 3'd1;
        a   = m_reg[ins[8:6]];
        b   = ins[12] ? {2'b00, ins[5:0]} : m_reg[ins[5:3]];
        sb.push_back(alu_f(op, a, b));
        if ((op == 3'd3 || op == 3'd4) && b == 8'h00) m_dz = 1'b1;
        exp_lat = (op == 3'd2) ? 4 : 3;

        instr = ins;
        instr_valid = 1'b1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: got %b expected 1", instr_ready);
        end
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin
            errors++;
            $display("FAIL operands: got a=%h b=%h op=%0d expected a=%h b=%h op=%0d",
                     alu_a, alu_b, alu_op, a, b, op);
        end
        checks++;
        if (dz_err !== m_dz) begin
            errors++;
            $display("FAIL dz_err: got %b expected %b", dz_err, m_dz);
        end
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_busy: got %b expected 0", instr_ready);
        end

        n = 2;
        while (done !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got no done, expected done in cycle %0d", exp_lat);
            void'(sb.pop_front());
            return;
        end else if (n != exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", n, exp_lat);
        end

        exp = sb.pop_front();
        checks++;
        if (done_result !== exp) begin
            errors++;
            $display("FAIL done_result: got %h expected %h", done_result, exp);
        end
        checks++;
        if (zero_flag !== (exp == 16'h0000)) begin
            errors++;
            $display("FAIL zero_flag: got %b expected %b", zero_flag, exp == 16'h0000);
        end

        m_reg[rd] = exp[7:0];
        if (op == 3'd2) m_reg[rdh] = exp[15:8];
        tick();
        checks++;
        if (done !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got done=%b ready=%b expected done=0 ready=1",
                     done, instr_ready);
        end
        check_regs("wb");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_dz = 1'b0;
        check_regs("reset");
        checks++;
        if ({instr_ready, done, dz_err, zero_flag} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b done=%b dz=%b z=%b expected 1 0 0 0",
                     instr_ready, done, dz_err, zero_flag);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, done_result} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outs: got a=%h b=%h op=%0d res=%h expected zeros",
                     alu_a, alu_b, alu_op, done_result);
        end
    endtask

    task automatic test_load_imm();
        issue(mk(3'd0, 1'b1, 3'd1, 3'd0, 6'd20));
        issue(mk(3'd0, 1'b1, 3'd2, 3'd0, 6'd7));
        check_reg("load_r1", 3'd1, 8'd20);
        check_reg("load_r2", 3'd2, 8'd7);
    endtask

    task automatic test_reg_sub();
        issue(mk(3'd1, 1'b0, 3'd3, 3'd1, {3'd2, 3'd0}));
        check_reg("sub_r3", 3'd3, 8'h0D);
        checks++;
        if (zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL sub_zero: got %b expected 0", zero_flag);
        end
    endtask

    task automatic test_mul_wrap();
        issue(mk(3'd0, 1'b1, 3'd1, 3'd0, 6'd50));
        for (int i = 0; i < 3; i++) issue(mk(3'd0, 1'b1, 3'd1, 3'd1, 6'd50));
        issue(mk(3'd0, 1'b0, 3'd2, 3'd0, {3'd1, 3'd0}));
        check_reg("mul_r2", 3'd2, 8'd200);
        issue(mk(3'd2, 1'b0, 3'd7, 3'd1, {3'd2, 3'd0}));
        check_reg("mul_r7", 3'd7, 8'h40);
        check_reg("mul_r0", 3'd0, 8'h9C);
    endtask

    task automatic test_div_zero();
        checks++;
        if (dz_err !== 1'b0) begin
            errors++;
            $display("FAIL dz_pre: got %b expected 0", dz_err);
        end
        issue(mk(3'd3, 1'b1, 3'd4, 3'd1, 6'd0));
        check_reg("dz_r4", 3'd4, 8'h00);
        checks++;
        if (dz_err !== 1'b1 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL dz_flags: got dz=%b z=%b expected 1 1", dz_err, zero_flag);
        end
    endtask

    task automatic test_back_to_back();
        issue(mk(3'd4, 1'b1, 3'd5, 3'd1, 6'd7));
        issue(mk(3'd5, 1'b0, 3'd6, 3'd1, {3'd2, 3'd0}));
        issue(mk(3'd6, 1'b0, 3'd3, 3'd7, {3'd0, 3'd0}));
        issue(mk(3'd7, 1'b0, 3'd3, 3'd3, {3'd3, 3'd0}));
        issue(mk(3'd1, 1'b1, 3'd6, 3'd6, 6'd1));
        checks++;
        if (dz_err !== 1'b1) begin
            errors++;
            $display("FAIL dz_sticky: got %b expected 1", dz_err);
        end
    endtask

    task automatic test_reset_mid();
        instr = mk(3'd0, 1'b1, 3'd5, 3'd0, 6'd33);
        instr_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({instr_ready, done, dz_err} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_flags: got rdy=%b done=%b dz=%b expected 1 0 0",
                     instr_ready, done, dz_err);
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_done: cycle %0d got 1 expected 0", i);
            end
        end
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_dz = 1'b0;
        check_regs("rst_mid");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_reg_sub();
        test_mul_wrap();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
